// File: rtl/mdio_phy_controller.sv
// PHY reset/boot sequencer and Clause-22 MDIO master with a single-outstanding
// valid/ready command port and a one-cycle response pulse.
module mdio_phy_controller #(
    parameter int          CLK_DIV      = 25,
    parameter logic [4:0]  PHY_ADDR     = 5'd7,
    parameter int          RESET_CYCLES = 100000,
    parameter int          BOOT_CYCLES  = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done,
    output logic        eth_mdc,
    output logic        eth_mdio_o,
    output logic        eth_mdio_t,
    input  logic        eth_mdio_i,
    output logic        eth_reset_n
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SHIFT, DONE} state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [RW-1:0] r_rstCnt;
    logic [BW-1:0] r_bootCnt;
    logic [DW-1:0] r_div;
    logic [5:0]    r_bit;
    logic [63:0]   r_frame;
    logic [15:0]   r_shift;
    logic [15:0]   r_rspRdata;
    logic          r_write;
    logic          r_taErr;
    logic          r_rspErr;
    logic          r_mdc;
    logic          r_mdioO;
    logic          r_mdioT;
    logic          r_ethResetN;
    logic          r_initDone;

    logic [63:0]   w_frameIn;
    logic          w_divEnd;
    logic          w_bitEnd;
    logic          w_lastBit;
    logic          w_sample;

    // Read frames carry all-ones in TA/data; the line is released there anyway.
    assign w_frameIn = {32'hFFFF_FFFF, 2'b01, cmd_write ? 2'b01 : 2'b10, PHY_ADDR, cmd_reg,
                        cmd_write ? 2'b10 : 2'b11, cmd_write ? cmd_wdata : 16'hFFFF};
    assign w_divEnd  = (r_div == DIV_LAST);
    assign w_bitEnd  = w_divEnd && r_mdc;
    assign w_lastBit = w_bitEnd && (r_bit == 6'd63);
    assign w_sample  = w_bitEnd && !r_write && (r_bit >= 6'd47);

    assign eth_mdc     = r_mdc;
    assign eth_mdio_o  = r_mdioO;
    assign eth_mdio_t  = r_mdioT;
    assign eth_reset_n = r_ethResetN;
    assign init_done   = r_initDone;
    assign rsp_rdata   = r_rspRdata;
    assign rsp_err     = r_rspErr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RST_HOLD;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            RST_HOLD: if (r_rstCnt == RST_LAST) w_stateNext = RST_WAIT;
            RST_WAIT: if (r_bootCnt == BOOT_LAST) w_stateNext = IDLE;
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_stateNext = SHIFT;
            end
            SHIFT:    if (w_lastBit) w_stateNext = DONE;
            DONE: begin
                rsp_valid   = 1'b1;
                w_stateNext = IDLE;
            end
            default:  w_stateNext = RST_HOLD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstCnt    <= '0;
            r_bootCnt   <= '0;
            r_div       <= '0;
            r_bit       <= '0;
            r_frame     <= '1;
            r_shift     <= '0;
            r_rspRdata  <= '0;
            r_write     <= 1'b0;
            r_taErr     <= 1'b0;
            r_rspErr    <= 1'b0;
            r_mdc       <= 1'b0;
            r_mdioO     <= 1'b1;
            r_mdioT     <= 1'b1;
            r_ethResetN <= 1'b0;
            r_initDone  <= 1'b0;
        end else begin
            if (r_state == RST_HOLD && r_rstCnt != RST_LAST)   r_rstCnt  <= r_rstCnt + 1'b1;
            if (r_state == RST_WAIT && r_bootCnt != BOOT_LAST) r_bootCnt <= r_bootCnt + 1'b1;
            if (w_stateNext == RST_WAIT) r_ethResetN <= 1'b1;
            if (w_stateNext == IDLE)     r_initDone  <= 1'b1;

            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_write <= cmd_write;
                    r_frame <= {w_frameIn[62:0], 1'b1};
                    r_mdioO <= w_frameIn[63];
                    r_mdioT <= 1'b0;
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_mdc   <= 1'b0;
                end
                SHIFT: begin
                    r_div <= w_divEnd ? '0 : r_div + 1'b1;
                    if (w_divEnd) r_mdc <= ~r_mdc;
                    // New bit goes out with the falling MDC edge; reads let go of the line at TA.
                    if (w_bitEnd && r_bit != 6'd63) begin
                        r_bit   <= r_bit + 1'b1;
                        r_mdioO <= r_frame[63];
                        r_frame <= {r_frame[62:0], 1'b1};
                        r_mdioT <= !r_write && (r_bit >= 6'd45);
                    end
                    if (w_sample) begin
                        if (r_bit == 6'd47) r_taErr <= eth_mdio_i;
                        else                r_shift <= {r_shift[14:0], eth_mdio_i};
                    end
                    if (w_lastBit) begin
                        r_mdioO    <= 1'b1;
                        r_mdioT    <= 1'b1;
                        r_rspRdata <= r_write ? 16'h0000 : {r_shift[14:0], eth_mdio_i};
                        r_rspErr   <= r_write ? 1'b0 : r_taErr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
